// File: rtl/control_fsm.sv
// control_fsm -- multi-cycle control sequencer for the WF8 datapath.
//
// Latches a 5-bit opcode into an internal instruction register and steps
// IDLE -> FETCH -> DECODE -> EXEC (-> MEM) -> FETCH, with a valid/ready
// fetch handshake and a req/ack memory handshake. Datapath strobes are the
// same as the old combinational decoder's, but gated per state. Adds PC
// sequencing, a memory timeout fault (sticky FAULT state) and a HALT state.
//
// Parameters:
//   ALU_MODE_W   width of alu_mode (defaults to `ALU_MODE_COUNT)
//   MEM_TIMEOUT  MEM cycles without mem_ack before FAULT (1..255)
//   CNT_W        width of the optional performance counters
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   run                 level; permits fetching new instructions
//   instr_valid/ready   opcode fetch handshake; opcode is the 5-bit opcode
//   branch_taken        branch compare result, sampled in EXEC
//   mem_ack             memory completion, sampled in MEM
//   alu_mode            ALU mode for the latched opcode
//   reg_b_write_en      register file write strobe
//   reg_b_read_en       register drives cpu_bus
//   alu_a_sel           0 = accumulator, 1 = PC
//   alu_b_sel           0 = register, 1 = immediate
//   pc_bus_en           PC drives cpu_bus
//   pc_inc, pc_load     one-cycle PC increment / load pulses
//   mem_req             memory request, held until ack
//   mem_write_en        store qualifier, valid while mem_req
//   busy, halted, fault status (fault is sticky until rst)
//   state               encoded state, for debug
//
// Optional feature, enabled by defining CTRL_PERF_CNT_EN:
//   cyc_cnt             cycles spent busy (saturating)
//   ret_cnt             pc_inc / pc_load pulses (saturating)

`ifndef ALU_MODE_COUNT
`define ALU_MODE_COUNT 3
`endif
`ifndef ALU_MODE_ADD
`define ALU_MODE_ADD 0
`endif
`ifndef ALU_MODE_SHIFT
`define ALU_MODE_SHIFT 1
`endif
`ifndef ALU_MODE_NOT
`define ALU_MODE_NOT 2
`endif
`ifndef ALU_MODE_AND
`define ALU_MODE_AND 3
`endif
`ifndef ALU_MODE_OR
`define ALU_MODE_OR 4
`endif
`ifndef ALU_MODE_BYPASS_A
`define ALU_MODE_BYPASS_A 5
`endif

module control_fsm #(
  parameter int unsigned ALU_MODE_W  = `ALU_MODE_COUNT,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [4:0]            opcode,
  input  logic                  branch_taken,
  input  logic                  mem_ack,
  output logic [ALU_MODE_W-1:0] alu_mode,
  output logic                  reg_b_write_en,
  output logic                  reg_b_read_en,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic                  pc_bus_en,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic                  mem_req,
  output logic                  mem_write_en,
  output logic                  busy,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      ret_cnt
`endif
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_cfg
    $error("control_fsm: MEM_TIMEOUT must be 1..255 and CNT_W at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SHIFT, C_NOT, C_AND, C_OR, C_JMP, C_CPY, C_CPYPC,
    C_LB, C_SB, C_NOP, C_BRANCH, C_HALT
  } op_class_t;

  state_t    cur;
  state_t    nxt;
  logic [4:0] ir;
  logic [7:0] tmo_cnt;
  op_class_t cls;
  logic      imm;
  logic      tmo_last;

  // Instruction class from the latched opcode.
  always_comb begin
    cls = C_NOP;
    case (ir[4:1])
      4'b0000, 4'b0001: cls = C_ADD;
      4'b0010, 4'b0011: cls = C_SHIFT;
      4'b0100:          cls = C_NOT;
      4'b0101:          cls = C_AND;
      4'b0110:          cls = C_OR;
      4'b0111:          cls = C_JMP;
      4'b1000:          cls = ir[0] ? C_CPYPC : C_CPY;
      4'b1001:          cls = C_LB;
      4'b1010:          cls = C_SB;
      4'b1011:          cls = C_NOP;
      default:          cls = (ir == 5'b11111) ? C_HALT : C_BRANCH;
    endcase
  end

  assign imm      = ir[1] && (cls == C_ADD || cls == C_SHIFT);
  // Counter holds the number of MEM cycles already spent without ack, so the
  // current cycle is the last allowed one when it equals MEM_TIMEOUT-1.
  assign tmo_last = (tmo_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_IDLE;
      ir      <= '0;
      tmo_cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && instr_valid && instr_ready) begin
        ir <= opcode;
      end
      if (cur == S_EXEC) begin
        tmo_cnt <= '0;
      end else if (cur == S_MEM && !mem_ack) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (run) nxt = S_FETCH;
      S_FETCH: begin
        if (!run)            nxt = S_IDLE;
        else if (instr_valid) nxt = S_DECODE;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        case (cls)
          C_HALT:     nxt = S_HALT;
          C_LB, C_SB: nxt = S_MEM;
          default:    nxt = S_FETCH;
        endcase
      end
      // Ack wins over a timeout landing in the same cycle.
      S_MEM: begin
        if (mem_ack)       nxt = S_FETCH;
        else if (tmo_last) nxt = S_FAULT;
      end
      S_HALT:   nxt = S_HALT;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready    = 1'b0;
    alu_mode       = ALU_MODE_W'(`ALU_MODE_ADD);
    reg_b_write_en = 1'b0;
    reg_b_read_en  = 1'b0;
    alu_a_sel      = 1'b0;
    alu_b_sel      = 1'b0;
    pc_bus_en      = 1'b0;
    pc_inc         = 1'b0;
    pc_load        = 1'b0;
    mem_req        = 1'b0;
    mem_write_en   = 1'b0;
    busy           = (cur == S_FETCH) || (cur == S_DECODE) ||
                     (cur == S_EXEC)  || (cur == S_MEM);
    halted         = (cur == S_HALT);
    fault          = (cur == S_FAULT);

    if (cur == S_FETCH) begin
      instr_ready = run;
    end

    if (cur == S_DECODE || cur == S_EXEC || cur == S_MEM) begin
      case (cls)
        C_SHIFT:                     alu_mode = ALU_MODE_W'(`ALU_MODE_SHIFT);
        C_NOT:                       alu_mode = ALU_MODE_W'(`ALU_MODE_NOT);
        C_AND:                       alu_mode = ALU_MODE_W'(`ALU_MODE_AND);
        C_OR:                        alu_mode = ALU_MODE_W'(`ALU_MODE_OR);
        C_CPY, C_CPYPC, C_LB, C_SB:  alu_mode = ALU_MODE_W'(`ALU_MODE_BYPASS_A);
        default:                     alu_mode = ALU_MODE_W'(`ALU_MODE_ADD);
      endcase
    end

    if (cur == S_EXEC || cur == S_MEM) begin
      alu_a_sel = (cls == C_BRANCH) || (cls == C_CPYPC);
      alu_b_sel = (cls == C_BRANCH) || imm;
      pc_bus_en = (cls == C_CPYPC) || (cls == C_JMP);
    end

    case (cur)
      S_EXEC: begin
        case (cls)
          C_ADD, C_SHIFT, C_NOT, C_AND, C_OR, C_CPY: begin
            reg_b_write_en = 1'b1;
            reg_b_read_en  = !imm;
            pc_inc         = 1'b1;
          end
          C_CPYPC: begin
            reg_b_write_en = 1'b1;
            pc_inc         = 1'b1;
          end
          C_BRANCH: begin
            pc_load = branch_taken;
            pc_inc  = !branch_taken;
          end
          C_JMP: begin
            reg_b_read_en = 1'b1;
            pc_load       = 1'b1;
          end
          C_NOP:   pc_inc = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (cls == C_SB) begin
          mem_write_en  = 1'b1;
          reg_b_read_en = 1'b1;
        end
        if (mem_ack) begin
          pc_inc         = 1'b1;
          reg_b_write_en = (cls == C_LB);
        end
      end
      default: ;
    endcase
  end

  assign state = cur;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (busy && cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
      if ((pc_inc || pc_load) && ret_cnt != '1) begin
        ret_cnt <= ret_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm -- randomized self-checking bench for control_fsm.
// Drives whole instructions (fetch wait, decode, exec, memory phase with a
// chosen ack delay) and compares every output each cycle against the
// expected behaviour derived from the instruction class rules.
// Optional counters are checked when CTRL_PERF_CNT_EN is defined.

module tb_control_fsm;

  localparam int MEM_TO = 4;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                 P_MEM = 4, P_HALT = 5, P_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [4:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ack = 1'b0;
  logic [2:0] alu_mode;
  logic       reg_b_write_en, reg_b_read_en, alu_a_sel, alu_b_sel, pc_bus_en;
  logic       pc_inc, pc_load, mem_req, mem_write_en, busy, halted, fault;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] cyc_cnt, ret_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit at_idle = 1'b1;
  int cyc_m = 0;
  int ret_m = 0;

  control_fsm #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ack(mem_ack), .alu_mode(alu_mode), .reg_b_write_en(reg_b_write_en),
    .reg_b_read_en(reg_b_read_en), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .pc_bus_en(pc_bus_en), .pc_inc(pc_inc),
    .pc_load(pc_load), .mem_req(mem_req), .mem_write_en(mem_write_en),
    .busy(busy), .halted(halted), .fault(fault), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  // ADD=0 SHIFT=1 NOT=2 AND=3 OR=4 BYPASS_A=5
  function automatic int mode_of(input logic [4:0] op);
    int hi = int'(op[4:1]);
    if (hi <= 1) return 0;
    if (hi <= 3) return 1;
    if (hi == 4) return 2;
    if (hi == 5) return 3;
    if (hi == 6) return 4;
    if (hi >= 8 && hi <= 10) return 5;
    return 0;
  endfunction

  // Packs outputs: [2:0] state [3] ready [4] wr [5] rd [6] asel [7] bsel
  // [8] pcbus [9] inc [10] load [11] req [12] mwe [13] busy [14] halted
  // [15] fault [18:16] mode.
  function automatic logic [31:0] observed();
    return {13'd0, alu_mode, fault, halted, busy, mem_write_en, mem_req,
            pc_load, pc_inc, pc_bus_en, alu_b_sel, alu_a_sel, reg_b_read_en,
            reg_b_write_en, instr_ready, state};
  endfunction

  function automatic logic [31:0] expect_out(input int ph, input logic [4:0] op,
                                             input bit r, input bit taken,
                                             input bit ack);
    int  hi     = int'(op[4:1]);
    bit  is_hlt = (op == 5'd31);
    bit  is_br  = (hi >= 12) && !is_hlt;
    bit  is_cpc = (op == 5'd17);
    bit  is_cpy = (hi == 8) && !is_cpc;
    bit  is_jmp = (hi == 7);
    bit  is_lb  = (hi == 9);
    bit  is_sb  = (hi == 10);
    bit  is_nop = (hi == 11);
    bit  is_alu = (hi <= 6);
    bit  immf   = (hi <= 3) && op[1];
    bit  rdy = 0, wr = 0, rd = 0, asel = 0, bsel = 0, pcb = 0;
    bit  inc = 0, ld = 0, req = 0, mwe = 0;
    int  md = 0;
    if (ph == P_FETCH) rdy = r;
    if (ph >= P_DECODE && ph <= P_MEM) md = mode_of(op);
    if (ph == P_EXEC || ph == P_MEM) begin
      asel = is_br || is_cpc;
      bsel = is_br || immf;
      pcb  = is_cpc || is_jmp;
    end
    if (ph == P_EXEC) begin
      if (is_alu || is_cpy || is_cpc) begin
        wr = 1; rd = !(immf || is_cpc); inc = 1;
      end else if (is_br) begin
        ld = taken; inc = !taken;
      end else if (is_jmp) begin
        rd = 1; ld = 1;
      end else if (is_nop) begin
        inc = 1;
      end
    end
    if (ph == P_MEM) begin
      req = 1; mwe = is_sb; rd = is_sb;
      if (ack) begin wr = is_lb; inc = 1; end
    end
    return {13'd0, 3'(md), bit'(ph == P_FAULT), bit'(ph == P_HALT),
            bit'(ph >= P_FETCH && ph <= P_MEM), mwe, req, ld, inc, pcb, bsel,
            asel, rd, wr, rdy, 3'(ph)};
  endfunction

  // One clock cycle: drive inputs after the falling edge, check shortly after.
  task automatic cyc(input string tag, input int ph, input logic [4:0] eop,
                     input bit r_rst, input bit r_run, input bit r_valid,
                     input logic [4:0] r_op, input bit r_taken, input bit r_ack,
                     input bit chk);
    logic [31:0] e;
    @(negedge clk);
    rst = r_rst; run = r_run; instr_valid = r_valid; opcode = r_op;
    branch_taken = r_taken; mem_ack = r_ack;
    #1;
    e = expect_out(ph, eop, r_run, r_taken, r_ack);
    if (chk) begin
      check(tag, observed(), e);
`ifdef CTRL_PERF_CNT_EN
      check({tag, "_cyc_cnt"}, 32'(cyc_cnt), 32'(cyc_m));
      check({tag, "_ret_cnt"}, 32'(ret_cnt), 32'(ret_m));
`endif
    end
    if (r_rst) begin
      cyc_m = 0; ret_m = 0;
    end else begin
      if (e[13] && cyc_m < 65535) cyc_m++;
      if ((e[9] || e[10]) && ret_m < 65535) ret_m++;
    end
  endtask

  task automatic do_reset(input int ph, input logic [4:0] eop);
    cyc("pre_rst", ph, eop, 1, rb(), rb(), 5'($urandom), rb(), rb(), 1);
    cyc("rst_idle", P_IDLE, 5'd0, 1, rb(), rb(), 5'($urandom), rb(), rb(), 1);
    at_idle = 1;
  endtask

  task automatic absorb(input int ph, input logic [4:0] eop);
    for (int i = 0; i < 3; i++)
      cyc(ph == P_HALT ? "halt_hold" : "fault_hold", ph, eop, 0, rb(), rb(),
          5'($urandom), rb(), rb(), 1);
    do_reset(ph, eop);
  endtask

  task automatic run_instr(input logic [4:0] op, input int vd, input int ad,
                           input bit taken, input bit rst_mem);
    bit done = 0;
    int guard = 0;
    int hi = int'(op[4:1]);
    while (!done) begin
      bit r = (guard > 12) ? 1'b1 : bit'($urandom % 4 != 0);
      if (at_idle) begin
        cyc("idle", P_IDLE, op, 0, r, rb(), 5'($urandom), rb(), rb(), 1);
        if (r) at_idle = 0;
      end else if (!r) begin
        cyc("fetch_norun", P_FETCH, op, 0, 0, rb(), 5'($urandom), rb(), rb(), 1);
        at_idle = 1;
      end else if (vd > 0) begin
        cyc("fetch_wait", P_FETCH, op, 0, 1, 0, 5'($urandom), rb(), rb(), 1);
        vd--;
      end else begin
        cyc("fetch_take", P_FETCH, op, 0, 1, 1, op, rb(), rb(), 1);
        done = 1;
      end
      guard++;
    end
    cyc("decode", P_DECODE, op, 0, rb(), rb(), 5'($urandom), rb(), rb(), 1);
    cyc("exec", P_EXEC, op, 0, rb(), rb(), 5'($urandom), taken, rb(), 1);
    if (op == 5'd31) begin
      absorb(P_HALT, op);
    end else if (hi == 9 || hi == 10) begin
      for (int k = 0; k < MEM_TO; k++) begin
        bit a = (k == ad);
        if (rst_mem && k == 1) begin
          cyc("mem_rst", P_MEM, op, 1, rb(), rb(), 5'($urandom), rb(), 0, 1);
          cyc("after_mem_rst", P_IDLE, op, 0, 0, rb(), 5'($urandom), rb(), rb(), 1);
          at_idle = 1;
          return;
        end
        cyc(a ? "mem_ack" : "mem_wait", P_MEM, op, 0, rb(), rb(),
            5'($urandom), rb(), a, 1);
        if (a) begin
          at_idle = 0;
          return;
        end
      end
      absorb(P_FAULT, op);
    end else begin
      at_idle = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc("rst0", P_IDLE, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0);
    cyc("reset", P_IDLE, 5'd0, 1, 0, 0, 5'd0, 0, 0, 1);
    // Directed instructions first.
    run_instr(5'b00000, 0, 0, 0, 0);   // ADD
    run_instr(5'b00010, 1, 0, 0, 0);   // ADDI
    run_instr(5'b10001, 0, 0, 0, 0);   // CPYPC
    run_instr(5'b11000, 0, 0, 1, 0);   // branch taken
    run_instr(5'b11000, 0, 0, 0, 0);   // branch not taken
    run_instr(5'b01110, 0, 0, 0, 0);   // JMPADR
    run_instr(5'b10010, 0, 3, 0, 0);   // LB, ack on 4th MEM cycle
    run_instr(5'b10100, 0, 3, 0, 0);   // SB, ack on last allowed cycle
    run_instr(5'b10100, 0, 99, 0, 0);  // SB timeout -> FAULT
    run_instr(5'b10010, 0, 3, 0, 1);   // reset mid-MEM
    run_instr(5'b00000, 0, 0, 0, 0);   // ADD, LB(ack+1), HALT
    run_instr(5'b10010, 0, 1, 0, 0);
    run_instr(5'b11111, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      logic [4:0] op = 5'($urandom);
      if (op == 5'd31 && ($urandom % 4) != 0) op = 5'd0;
      run_instr(op, int'($urandom % 3), int'($urandom % 6), rb(),
                bit'($urandom % 20 == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
